// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART TX among four byte-stream requesters.
// Optional stall timeout enabled with `define UART_TX_SCHED_TIMEOUT_EN.
module uart_tx_scheduler #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req_valid,
    input  logic [31:0] req_data,
    input  logic [3:0]  req_last,
    output logic [3:0]  req_ready,
    output logic [3:0]  grant,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic        abort
);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_HI,
        WAIT_LO
    } state_t;

    state_t      r_state;
    logic [3:0]  r_grant;
    logic [1:0]  r_gidx;
    logic [1:0]  r_last_grant;
    logic        r_last;
    logic [7:0]  r_tx_data;
    logic        r_tx_start;

    logic        w_pick_any;
    logic [1:0]  w_pick_idx;
    logic        w_accept;
    logic [7:0]  w_byte;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

`ifdef UART_TX_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_stall;
    logic          r_abort;
    assign abort = r_abort;
`else
    assign abort = 1'b0;
`endif

    // Round-robin pick: nearest valid requester after the last owner wins.
    always_comb begin
        logic [1:0] idx;
        w_pick_any = 1'b0;
        w_pick_idx = r_last_grant;
        idx        = r_last_grant;
        for (int k = 4; k >= 1; k--) begin
            idx = r_last_grant + 2'(k);
            if (req_valid[idx]) begin
                w_pick_any = 1'b1;
                w_pick_idx = idx;
            end
        end
    end

    assign req_ready = (r_state == SEND && !tx_busy) ? (r_grant & req_valid) : 4'b0000;
    assign w_accept  = |req_ready;
    assign w_byte    = req_data[{r_gidx, 3'b000} +: 8];

    assign grant     = r_grant;
    assign tx_data   = r_tx_data;
    assign tx_start  = r_tx_start;

    // Message FSM: grant, byte capture, and UART busy handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_grant      <= 4'b0000;
            r_gidx       <= 2'd0;
            r_last_grant <= 2'd3;
            r_last       <= 1'b0;
            r_tx_data    <= 8'h00;
            r_tx_start   <= 1'b0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
            r_stall      <= '0;
            r_abort      <= 1'b0;
`endif
        end else begin
            r_tx_start <= 1'b0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
            r_abort    <= 1'b0;
`endif
            unique case (r_state)
                IDLE: begin
                    if (w_pick_any) begin
                        r_grant <= 4'b0001 << w_pick_idx;
                        r_gidx  <= w_pick_idx;
                        r_state <= SEND;
`ifdef UART_TX_SCHED_TIMEOUT_EN
                        r_stall <= '0;
`endif
                    end
                end
                SEND: begin
                    if (w_accept) begin
                        r_tx_data  <= w_byte;
                        r_tx_start <= 1'b1;
                        r_last     <= req_last[r_gidx];
                        r_state    <= WAIT_HI;
`ifdef UART_TX_SCHED_TIMEOUT_EN
                        r_stall    <= '0;
`endif
                    end
`ifdef UART_TX_SCHED_TIMEOUT_EN
                    else if (!req_valid[r_gidx]) begin
                        if (r_stall == CW'(TIMEOUT_CYCLES - 1)) begin
                            r_abort      <= 1'b1;
                            r_grant      <= 4'b0000;
                            r_last_grant <= r_gidx;
                            r_state      <= IDLE;
                            r_stall      <= '0;
                        end else begin
                            r_stall <= r_stall + 1'b1;
                        end
                    end else begin
                        r_stall <= '0;
                    end
`endif
                end
                WAIT_HI: begin
                    if (tx_busy) begin
                        r_state <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (!tx_busy) begin
                        if (r_last) begin
                            r_grant      <= 4'b0000;
                            r_last_grant <= r_gidx;
                            r_state      <= IDLE;
                        end else begin
                            r_state <= SEND;
`ifdef UART_TX_SCHED_TIMEOUT_EN
                            r_stall <= '0;
`endif
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: cycle table plus
// multi-cycle sequences with a simple UART busy model.
`timescale 1ns/1ps
module tb_uart_tx_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = 4'h0;
    logic [31:0] req_data = 32'h0;
    logic [3:0]  req_last = 4'h0;
    logic [3:0]  req_ready;
    logic [3:0]  grant;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic        abort;

    logic        busy_drv = 1'b0;
    logic        model_en = 1'b0;
    int          bcnt;
    logic [7:0]  frames[$];
    int          n_abort = 0;
    int          viol = 0;
    logic        c_active = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_tx_scheduler #(.TIMEOUT_CYCLES(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .grant     (grant),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .abort     (abort)
    );

    always @* tx_busy = model_en ? (bcnt != 0) : busy_drv;

    always @(posedge clk or posedge rst) begin
        if (rst) bcnt <= 0;
        else if (tx_start) bcnt <= 10;
        else if (bcnt != 0) bcnt <= bcnt - 1;
    end

    always @(posedge clk) begin
        if (!rst && tx_start) frames.push_back(tx_data);
        if (!rst && abort) n_abort++;
        if (c_active && req_ready[1]) viol++;
    end

    typedef struct {
        logic [3:0]  v;
        logic [31:0] d;
        logic [3:0]  l;
        logic        b;
        logic [3:0]  eg;
        logic [3:0]  er;
        logic        es;
        logic [7:0]  ed;
    } vec_t;

    vec_t tbl[26];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = 4'h0;
        req_data = 32'h0;
        req_last = 4'h0;
        busy_drv = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        frames.delete();
    endtask

    // Offer one byte from requester r; returns at the negedge after acceptance.
    task automatic send(input int r, input logic [7:0] d, input logic l);
        bit ok = 0;
        req_valid[r] = 1'b1;
        req_data[8*r +: 8] = d;
        req_last[r] = l;
        for (int k = 0; k < 300 && !ok; k++) begin
            #1;
            if (req_ready[r]) ok = 1;
            @(negedge clk);
        end
        req_valid[r] = 1'b0;
        chk($sformatf("send_r%0d_%0h_accepted", r, d), 32'(ok), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        bit ok = 0;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge clk);
            #1;
            if (grant == 4'h0) ok = 1;
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    initial begin
        int na;
        int nf;
        logic [3:0] w;
        bit re;
        bit done;

        tbl[0]  = '{4'h0, 32'h00000000, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00};
        tbl[1]  = '{4'h1, 32'h000000A1, 4'h1, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00};
        tbl[2]  = '{4'h1, 32'h000000A1, 4'h1, 1'b0, 4'h1, 4'h1, 1'b0, 8'h00};
        tbl[3]  = '{4'h0, 32'h00000000, 4'h0, 1'b0, 4'h1, 4'h0, 1'b1, 8'hA1};
        tbl[4]  = '{4'h0, 32'h00000000, 4'h0, 1'b1, 4'h1, 4'h0, 1'b0, 8'hA1};
        tbl[5]  = '{4'h0, 32'h00000000, 4'h0, 1'b1, 4'h1, 4'h0, 1'b0, 8'hA1};
        tbl[6]  = '{4'h0, 32'h00000000, 4'h0, 1'b0, 4'h1, 4'h0, 1'b0, 8'hA1};
        tbl[7]  = '{4'hF, 32'h44332211, 4'hF, 1'b0, 4'h0, 4'h0, 1'b0, 8'hA1};
        tbl[8]  = '{4'hF, 32'h44332211, 4'hF, 1'b1, 4'h2, 4'h0, 1'b0, 8'hA1};
        tbl[9]  = '{4'hF, 32'h44332211, 4'hF, 1'b0, 4'h2, 4'h2, 1'b0, 8'hA1};
        tbl[10] = '{4'hF, 32'h44332211, 4'hF, 1'b0, 4'h2, 4'h0, 1'b1, 8'h22};
        tbl[11] = '{4'hF, 32'h44332211, 4'hF, 1'b1, 4'h2, 4'h0, 1'b0, 8'h22};
        tbl[12] = '{4'hF, 32'h44332211, 4'hF, 1'b0, 4'h2, 4'h0, 1'b0, 8'h22};
        tbl[13] = '{4'hF, 32'h44332211, 4'hF, 1'b0, 4'h0, 4'h0, 1'b0, 8'h22};
        tbl[14] = '{4'h0, 32'h00000000, 4'h0, 1'b0, 4'h4, 4'h0, 1'b0, 8'h22};
        tbl[15] = '{4'hB, 32'h00000000, 4'h0, 1'b0, 4'h4, 4'h0, 1'b0, 8'h22};
        tbl[16] = '{4'h4, 32'h005C0000, 4'h0, 1'b0, 4'h4, 4'h4, 1'b0, 8'h22};
        tbl[17] = '{4'h0, 32'h00000000, 4'h0, 1'b0, 4'h4, 4'h0, 1'b1, 8'h5C};
        tbl[18] = '{4'h0, 32'h00000000, 4'h0, 1'b1, 4'h4, 4'h0, 1'b0, 8'h5C};
        tbl[19] = '{4'h0, 32'h00000000, 4'h0, 1'b0, 4'h4, 4'h0, 1'b0, 8'h5C};
        tbl[20] = '{4'hF, 32'h007E0000, 4'h4, 1'b0, 4'h4, 4'h4, 1'b0, 8'h5C};
        tbl[21] = '{4'h0, 32'h00000000, 4'h0, 1'b0, 4'h4, 4'h0, 1'b1, 8'h7E};
        tbl[22] = '{4'h0, 32'h00000000, 4'h0, 1'b1, 4'h4, 4'h0, 1'b0, 8'h7E};
        tbl[23] = '{4'h0, 32'h00000000, 4'h0, 1'b0, 4'h4, 4'h0, 1'b0, 8'h7E};
        tbl[24] = '{4'hF, 32'h99000000, 4'hF, 1'b0, 4'h0, 4'h0, 1'b0, 8'h7E};
        tbl[25] = '{4'hF, 32'h99000000, 4'hF, 1'b0, 4'h8, 4'h8, 1'b0, 8'h7E};

        // Reset values while rst is held with requests pending.
        req_valid = 4'hF;
        req_data = 32'hFFFFFFFF;
        #2;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_start", 32'(tx_start), 32'h0);
        chk("rst_data", 32'(tx_data), 32'h00);
        chk("rst_abort", 32'(abort), 32'h0);

        // Cycle table, tx_busy driven directly.
        do_reset();
        for (int i = 0; i < 26; i++) begin
            req_valid = tbl[i].v;
            req_data  = tbl[i].d;
            req_last  = tbl[i].l;
            busy_drv  = tbl[i].b;
            #1;
            chk($sformatf("row%0d_grant", i), 32'(grant), 32'(tbl[i].eg));
            chk($sformatf("row%0d_ready", i), 32'(req_ready), 32'(tbl[i].er));
            chk($sformatf("row%0d_start", i), 32'(tx_start), 32'(tbl[i].es));
            chk($sformatf("row%0d_data", i), 32'(tx_data), 32'(tbl[i].ed));
            chk($sformatf("row%0d_abort", i), 32'(abort), 32'h0);
            @(negedge clk);
        end

        // Four-byte message from requester 0.
        model_en = 1'b1;
        do_reset();
        send(0, 8'h50, 1'b0);
        send(0, 8'h4F, 1'b0);
        send(0, 8'h4C, 1'b0);
        send(0, 8'h4F, 1'b1);
        wait_idle("msg4_idle");
        chk("msg4_count", 32'(frames.size()), 32'd4);
        if (frames.size() == 4) begin
            chk("msg4_b0", 32'(frames[0]), 32'h50);
            chk("msg4_b1", 32'(frames[1]), 32'h4F);
            chk("msg4_b2", 32'(frames[2]), 32'h4C);
            chk("msg4_b3", 32'(frames[3]), 32'h4F);
        end

        // All four request from reset; requester 0 re-requests after its turn.
        do_reset();
        req_valid = 4'hF;
        req_last = 4'hF;
        req_data = 32'hB3B2B1B0;
        re = 0;
        done = 0;
        for (int c = 0; c < 600 && !done; c++) begin
            #1;
            w = req_ready;
            @(posedge clk);
            #1;
            if (w[0] && !re) begin
                req_data[7:0] = 8'hC0;
                re = 1;
            end else begin
                req_valid = req_valid & ~w;
            end
            if (frames.size() == 5 && grant == 4'h0) done = 1;
            @(negedge clk);
        end
        chk("rr_done", 32'(done), 32'd1);
        chk("rr_count", 32'(frames.size()), 32'd5);
        if (frames.size() == 5) begin
            chk("rr_0", 32'(frames[0]), 32'hB0);
            chk("rr_1", 32'(frames[1]), 32'hB1);
            chk("rr_2", 32'(frames[2]), 32'hB2);
            chk("rr_3", 32'(frames[3]), 32'hB3);
            chk("rr_4", 32'(frames[4]), 32'hC0);
        end

        // Requester 1 must not be served during requester 2's message.
        do_reset();
        send(2, 8'hD1, 1'b0);
        c_active = 1'b1;
        req_valid[1] = 1'b1;
        req_data[15:8] = 8'hE1;
        req_last[1] = 1'b1;
        send(2, 8'hD2, 1'b1);
        for (int k = 0; k < 300 && grant[2]; k++) @(negedge clk);
        c_active = 1'b0;
        send(1, 8'hE1, 1'b1);
        wait_idle("hold_idle");
        chk("hold_viol", 32'(viol), 32'd0);
        chk("hold_count", 32'(frames.size()), 32'd3);
        if (frames.size() == 3) begin
            chk("hold_0", 32'(frames[0]), 32'hD1);
            chk("hold_1", 32'(frames[1]), 32'hD2);
            chk("hold_2", 32'(frames[2]), 32'hE1);
        end

        // Reset during WAIT_LO of byte 2.
        do_reset();
        send(0, 8'hF1, 1'b0);
        send(0, 8'hF2, 1'b0);
        repeat (5) @(negedge clk);
        chk("mid_busy", 32'(tx_busy), 32'd1);
        req_valid[0] = 1'b1;
        req_data[7:0] = 8'hF3;
        busy_drv = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_grant", 32'(grant), 32'h0);
        chk("mid_ready", 32'(req_ready), 32'h0);
        chk("mid_start", 32'(tx_start), 32'h0);
        chk("mid_data", 32'(tx_data), 32'h00);
        chk("mid_abort", 32'(abort), 32'h0);
        nf = frames.size();
        @(negedge clk);
        req_valid = 4'h0;
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("mid_nostart", 32'(frames.size()), 32'(nf));
        chk("mid_frames", 32'(nf), 32'd2);

        // Requester 3 stalls after one byte.
        do_reset();
        na = n_abort;
        send(3, 8'h3A, 1'b0);
        repeat (40) @(negedge clk);
        #1;
`ifdef UART_TX_SCHED_TIMEOUT_EN
        chk("stall_abort", 32'(n_abort - na), 32'd1);
        chk("stall_grant", 32'(grant), 32'h0);
`else
        chk("stall_abort", 32'(n_abort - na), 32'd0);
        chk("stall_grant", 32'(grant), 32'h8);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
